// File: rtl/uart_display_scroller.sv
// Filters received UART bytes into hex digit codes, buffers them in a small
// FIFO and scrolls them into a four-digit display word from the right.
//
// state | meaning
// IDLE  | nothing to show, timer held at 0
// COUNT | waiting out one scroll period
// SHIFT | pop one code and shift it into word[3:0]
module uart_display_scroller #(
  parameter int         SCROLL_TICKS = 25000000,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [3:0] ERR_CODE     = 4'hE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_perror,
  input  logic                          rx_ferror,
  input  logic                          clear,
  output logic [15:0]                   word,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(SCROLL_TICKS);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(SCROLL_TICKS - 1);

  typedef enum logic [1:0] {IDLE, COUNT, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_nxt;
  logic            enc_valid;
  logic [3:0]      enc_code;
  logic            full, empty, push, pop, drop;

  assign full  = (fifo_count == CNT_FULL);
  assign empty = (fifo_count == '0);
  assign pop   = (state == SHIFT) && !empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the byte.
  assign push  = enc_valid && (!full || pop);
  assign drop  = enc_valid && full && !pop;
  assign busy  = (state != IDLE) || !empty;

  // Map a received byte to a digit code; errored bytes always produce ERR_CODE.
  always_comb begin
    enc_valid = 1'b0;
    enc_code  = 4'h0;
    if (rx_valid) begin
      if (rx_perror || rx_ferror) begin
        enc_valid = 1'b1;
        enc_code  = ERR_CODE;
      end else if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
        enc_valid = 1'b1;
        enc_code  = rx_data[3:0];
      end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                   (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
        enc_valid = 1'b1;
        enc_code  = rx_data[3:0] + 4'd9;
      end
    end
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop) begin
      count_nxt = fifo_count + CNT_ONE;
    end else if (pop && !push) begin
      count_nxt = fifo_count - CNT_ONE;
    end
  end

  // Scroll sequencing: next state and timer.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (!empty) begin
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (timer == T_LAST) begin
          state_nxt = SHIFT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      SHIFT: begin
        timer_nxt = '0;
        state_nxt = (count_nxt != '0) ? COUNT : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Control registers, pointers and display word; reset and clear both flush.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state      <= IDLE;
      timer      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      word       <= 16'h0000;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      fifo_count <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        word   <= {word[11:0], mem[rd_ptr]};
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Code storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && !clear && push) begin
      mem[wr_ptr] <= enc_code;
    end
  end

endmodule

// File: tb/tb_uart_display_scroller.sv
// Self-checking bench for uart_display_scroller: a queue-based model with
// scheduled shift times is compared against the DUT on every cycle.
module tb_uart_display_scroller;

  localparam int ST    = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_perror = 1'b0;
  logic        rx_ferror = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] word;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_display_scroller #(
    .SCROLL_TICKS(ST),
    .FIFO_DEPTH  (DEPTH),
    .ERR_CODE    (4'hE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_perror (rx_perror),
    .rx_ferror (rx_ferror),
    .clear     (clear),
    .word      (word),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending codes, display word, sticky flag and the edge
  // number at which the next scroll step is due (-1 when none is scheduled).
  logic [3:0]  q[$];
  logic [15:0] m_word = 16'h0000;
  logic        m_ovf = 1'b0;
  longint      edge_n = 0;
  longint      next_shift = -1;
  bit          model_ok = 1'b0;

  function automatic int encode(input logic v, input logic [7:0] d,
                                input logic pe, input logic fe);
    if (!v) return -1;
    if (pe || fe) return 14;
    if (d >= 8'h30 && d <= 8'h39) return int'(d) - 48;
    if (d >= 8'h41 && d <= 8'h46) return int'(d) - 55;
    if (d >= 8'h61 && d <= 8'h66) return int'(d) - 87;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs applied for that edge.
  always @(posedge clk) begin
    int c;
    bit sh;
    edge_n++;
    if (!reset || clear) begin
      q.delete();
      m_word     = 16'h0000;
      m_ovf      = 1'b0;
      next_shift = -1;
      if (!reset) model_ok = 1'b1;
    end else begin
      c  = encode(rx_valid, rx_data, rx_perror, rx_ferror);
      sh = (next_shift == edge_n) && (q.size() > 0);
      if (sh) m_word = {m_word[11:0], q.pop_front()};
      if (c >= 0) begin
        if (q.size() < DEPTH) q.push_back(4'(c));
        else m_ovf = 1'b1;
      end
      if (sh) next_shift = (q.size() > 0) ? edge_n + ST + 1 : -1;
      else if (next_shift < 0 && q.size() > 0) next_shift = edge_n + ST + 2;
    end
  end

  // Cycle-by-cycle comparison, sampled away from the rising edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("word", 32'(word), 32'(m_word));
      chk("fifo_count", 32'(fifo_count), q.size());
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(q.size() != 0));
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic pe,
                       input logic fe, input logic cl);
    @(negedge clk);
    rx_valid  = v;
    rx_data   = d;
    rx_perror = pe;
    rx_ferror = fe;
    clear     = cl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int cat;
    logic [7:0] d;
    reset = 1'b0;
    idle(5);
    reset = 1'b1;
    idle(20);
    chk("lit_reset_word", 32'(word), 32'h0000);
    chk("lit_reset_count", 32'(fifo_count), 0);
    chk("lit_reset_busy", 32'(busy), 0);
    chk("lit_reset_ovf", 32'(overflow), 0);

    // single '7'
    drive(1'b1, 8'h37, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("lit_single_count", 32'(fifo_count), 1);
    idle(6);
    chk("lit_single_word", 32'(word), 32'h0007);
    chk("lit_single_busy", 32'(busy), 0);
    chk("lit_model_single", 32'(m_word), 32'h0007);

    // burst "A194" then 'c'
    drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h39, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    idle(26);
    chk("lit_burst_word", 32'(word), 32'hA194);
    drive(1'b1, 8'h63, 1'b0, 1'b0, 1'b0);
    idle(11);
    chk("lit_lower_c", 32'(word), 32'h194C);

    // ignored bytes and error bytes
    drive(1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("lit_filter_count", 32'(fifo_count), 0);
    drive(1'b1, 8'h31, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h35, 1'b1, 1'b0, 1'b0);
    idle(16);
    chk("lit_err_word", 32'(word), 32'h4CEE);

    // ten back-to-back digits: one pop lands mid-burst, byte '9' is dropped
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("lit_ovf_count", 32'(fifo_count), 8);
    chk("lit_ovf_flag", 32'(overflow), 1);
    idle(60);
    chk("lit_ovf_word", 32'(word), 32'h5678);
    chk("lit_ovf_sticky", 32'(overflow), 1);

    // clear, then fill so a byte lands on a SHIFT cycle with the FIFO full
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("lit_clear_ovf", 32'(overflow), 0);
    chk("lit_clear_word", 32'(word), 32'h0000);
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h41 + (i % 6)), 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 8'h39, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("lit_full_shift_count", 32'(fifo_count), 8);
    chk("lit_full_shift_ovf", 32'(overflow), 0);
    idle(60);

    // clear in the middle of a scroll period
    drive(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    idle(3);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("lit_midclear_word", 32'(word), 32'h0000);
    chk("lit_midclear_count", 32'(fifo_count), 0);
    idle(20);
    chk("lit_midclear_quiet", 32'(word), 32'h0000);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cat = int'($urandom_range(0, 3));
      case (cat)
        0: d = 8'(8'h30 + $urandom_range(0, 9));
        1: d = 8'(8'h41 + $urandom_range(0, 5));
        2: d = 8'(8'h61 + $urandom_range(0, 5));
        default: d = 8'($urandom_range(0, 255));
      endcase
      drive(($urandom_range(0, 3) == 0), d, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
      reset = ($urandom_range(0, 499) != 0);
    end
    reset = 1'b1;
    idle(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
